// File: rtl/rv32_multicycle_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle controller: opcodes, select
// encodings, trap causes and FSM state encoding.
package rv32_multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;

  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
  localparam logic [1:0] CAUSE_FETCH_TIME = 2'd2;
  localparam logic [1:0] CAUSE_DATA_TIME  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return op inside {OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_LUI, OPC_BRANCH,
                      OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR};
  endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive waiting cycles and pulses expired in the
// cycle that would be the TIMEOUT-th wait. TIMEOUT of 0 disables it.
module rv32_multicycle_ctrl_mem_watchdog #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] Limit = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q;

  // Any cycle not spent waiting restarts the count, so FETCH and MEM share it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end else begin
      count_q <= '0;
    end
  end

  assign expired = (TIMEOUT != 0) && en && (count_q == Limit);

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
module rv32_multicycle_ctrl
  import rv32_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic                alu_result0,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic                ir_we,
  output logic [1:0]          alu_a_sel,
  output logic                alu_b_sel,
  output logic                alu_force_add,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic [RETIRE_W-1:0] retired,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_e              state_q, state_d;
  logic                take_q, take_d;
  logic [1:0]          cause_q, cause_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;
  logic                wd_en, wd_expired;

  logic is_load, is_store, is_branch;
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  // Kept outside the FSM process so the watchdog pulse does not loop back into it.
  assign wd_en = ((state_q == StFetch) && !imem_ready) ||
                 ((state_q == StMem) && !dmem_ready);

  rv32_multicycle_ctrl_mem_watchdog #(
    .TIMEOUT_W(TIMEOUT_W),
    .TIMEOUT  (TIMEOUT)
  ) u_mem_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      take_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      take_q  <= take_d;
      cause_q <= cause_d;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  // Operand selects are driven in EXEC and held through MEM.
  always_comb begin
    alu_a_sel     = A_SEL_RS1;
    alu_b_sel     = B_SEL_RS2;
    alu_force_add = 1'b0;
    if ((state_q == StExec) || (state_q == StMem)) begin
      case (opcode)
        OPC_OP_IMM, OPC_LOAD, OPC_STORE: alu_b_sel = B_SEL_IMM;
        OPC_AUIPC: begin
          alu_a_sel = A_SEL_PC;
          alu_b_sel = B_SEL_IMM;
        end
        OPC_LUI: begin
          alu_a_sel = A_SEL_ZERO;
          alu_b_sel = B_SEL_IMM;
        end
        OPC_JALR: begin
          alu_b_sel     = B_SEL_IMM;
          alu_force_add = 1'b1;
        end
        OPC_JAL:  alu_force_add = 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    take_d   = take_q;
    cause_d  = cause_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_SEL_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PLUS4;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (wd_expired) begin
          state_d = StTrap;
          cause_d = CAUSE_FETCH_TIME;
        end
      end
      StDecode: begin
        if (is_legal_opcode(opcode)) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      StExec: begin
        if (is_branch) take_d = alu_result0;
        state_d = (is_load || is_store) ? StMem : StWb;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = run ? StFetch : StIdle;
          end else begin
            state_d = StWb;
          end
        end else if (wd_expired) begin
          state_d = StTrap;
          cause_d = CAUSE_DATA_TIME;
        end
      end
      StWb: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        reg_we = !is_branch;
        case (opcode)
          OPC_LOAD:           wb_sel = WB_SEL_LOAD;
          OPC_JAL, OPC_JALR:  wb_sel = WB_SEL_PC4;
          default:            wb_sel = WB_SEL_ALU;
        endcase
        case (opcode)
          OPC_BRANCH: pc_sel = take_q ? PC_SEL_BRANCH : PC_SEL_PLUS4;
          OPC_JAL:    pc_sel = PC_SEL_BRANCH;
          OPC_JALR:   pc_sel = PC_SEL_JALR;
          default:    pc_sel = PC_SEL_PLUS4;
        endcase
        state_d = run ? StFetch : StIdle;
      end
      StTrap: ;
      default: state_d = StIdle;
    endcase
  end

  assign retired    = retired_q;
  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Randomised instruction-level bench for rv32_multicycle_ctrl against an expected
// per-phase control table.
module tb_rv32_multicycle_ctrl;

  localparam int unsigned TO = 5;
  localparam int unsigned RW = 4;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       force_add;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst_n, run, alu_result0, imem_ready, dmem_ready;
  logic [6:0]    opcode;
  logic          imem_req, dmem_req, dmem_we, ir_we, alu_b_sel, alu_force_add;
  logic          reg_we, pc_we, trap;
  logic [1:0]    alu_a_sel, wb_sel, pc_sel, trap_cause;
  logic [RW-1:0] retired;
  logic [13:0]   got_ctl;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;
  logic [6:0] legal_ops [9] = '{LOAD, STORE, AUIPC, LUI, BRANCH, OP, OP_IMM, JAL, JALR};

  always #5 clk = ~clk;

  rv32_multicycle_ctrl #(
    .TIMEOUT_W(8),
    .TIMEOUT  (TO),
    .RETIRE_W (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .alu_result0  (alu_result0),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .ir_we        (ir_we),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_force_add(alu_force_add),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .retired      (retired),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  assign got_ctl = {imem_req, dmem_req, dmem_we, ir_we, alu_a_sel, alu_b_sel, alu_force_add,
                    reg_we, wb_sel, pc_we, pc_sel};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t exec_ctl(input logic [6:0] op);
    ctl_t e;
    e = '0;
    case (op)
      OP_IMM, LOAD, STORE: e.b_sel = 1'b1;
      AUIPC:   begin e.a_sel = 2'd1; e.b_sel = 1'b1; end
      LUI:     begin e.a_sel = 2'd2; e.b_sel = 1'b1; end
      JALR:    begin e.b_sel = 1'b1; e.force_add = 1'b1; end
      JAL:     e.force_add = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    alu_result0 = 1'b0; opcode = 7'd0;
    next_cycle();
    @(negedge clk);
    check("rst_ctl", got_ctl, 0);
    check("rst_trap", {trap, trap_cause}, 0);
    check("rst_retired", retired, 0);
    exp_retired = 0;
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Leave IDLE: one idle cycle with run high, then FETCH.
  task automatic start();
    run = 1'b1;
    @(negedge clk);
    check("idle_ctl", got_ctl, 0);
    next_cycle();
  endtask

  task automatic expect_trap(input logic [1:0] cause);
    repeat (3) begin
      @(negedge clk);
      check("trap_ctl", got_ctl, 0);
      check("trap_flag", trap, 1);
      check("trap_cause", trap_cause, cause);
      check("trap_retired", retired, exp_retired % 16);
      next_cycle();
    end
  endtask

  // Runs one instruction starting in FETCH. A delay of TO or more never raises ready.
  task automatic do_instr(input logic [6:0] op, input int fdel, input int mdel, input logic br,
                          input logic drop_run);
    ctl_t e;
    logic legal, mem, st;
    legal = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1'b1;
    mem = (op == LOAD) || (op == STORE);
    st  = (op == STORE);
    opcode = op;
    for (int i = 0; i <= fdel && i < int'(TO); i++) begin
      imem_ready = (i == fdel);
      @(negedge clk);
      e = '0; e.imem_req = 1'b1; e.ir_we = (i == fdel);
      check("fetch", got_ctl, e);
      next_cycle();
    end
    imem_ready = 1'b0;
    if (fdel >= int'(TO)) begin
      expect_trap(2'd2);
      return;
    end
    @(negedge clk);
    check("decode", got_ctl, 0);
    next_cycle();
    if (!legal) begin
      expect_trap(2'd1);
      return;
    end
    alu_result0 = br;
    @(negedge clk);
    check("exec", got_ctl, exec_ctl(op));
    next_cycle();
    alu_result0 = ~br;
    if (mem) begin
      for (int j = 0; j <= mdel && j < int'(TO); j++) begin
        dmem_ready = (j == mdel);
        if (drop_run && j == 0) run = 1'b0;
        @(negedge clk);
        e = exec_ctl(op); e.dmem_req = 1'b1; e.dmem_we = st; e.pc_we = st && (j == mdel);
        check("mem", got_ctl, e);
        next_cycle();
      end
      dmem_ready = 1'b0;
      if (mdel >= int'(TO)) begin
        expect_trap(2'd3);
        return;
      end
    end
    if (!st) begin
      @(negedge clk);
      e = '0; e.pc_we = 1'b1; e.reg_we = (op != BRANCH);
      e.wb_sel = (op == LOAD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
      e.pc_sel = (op == BRANCH) ? (br ? 2'd1 : 2'd0) : (op == JAL) ? 2'd1 :
                 (op == JALR) ? 2'd2 : 2'd0;
      check("wb", got_ctl, e);
      next_cycle();
    end
    exp_retired++;
    check("retired", retired, exp_retired % 16);
    if (!run) begin
      @(negedge clk);
      check("idle_after", {got_ctl, trap}, 0);
      run = 1'b1;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_dut();
    start();
    do_instr(OP, 2, 0, 1'b0, 1'b0);
    do_instr(BRANCH, 0, 0, 1'b1, 1'b0);
    do_instr(BRANCH, 1, 0, 1'b0, 1'b0);
    do_instr(LOAD, 0, 4, 1'b0, 1'b0);
    do_instr(STORE, 1, 2, 1'b0, 1'b0);
    do_instr(JAL, 0, 0, 1'b0, 1'b0);
    do_instr(JALR, 0, 0, 1'b0, 1'b0);
    do_instr(AUIPC, 0, 0, 1'b0, 1'b0);
    do_instr(LUI, 0, 0, 1'b0, 1'b0);
    do_instr(OP_IMM, 4, 0, 1'b0, 1'b0);
    do_instr(LOAD, 0, 1, 1'b0, 1'b1);
    do_instr(STORE, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      do_instr(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
    end
    do_instr(7'b0000000, 0, 0, 1'b0, 1'b0);
    reset_dut();
    start();
    do_instr(OP, 0, 0, 1'b0, 1'b0);
    do_instr(OP, 5, 0, 1'b0, 1'b0);
    reset_dut();
    start();
    do_instr(LOAD, 1, 5, 1'b0, 1'b0);
    reset_dut();
    start();
    for (int k = 0; k < 16; k++) do_instr(OP_IMM, 0, 0, 1'b0, 1'b0);
    check("wrap", retired, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
